// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
// Bundles the signals between decode, the ID/EX register and the EX stage.
//   master : decode / hazard / forwarding-source side (drives stall, flush,
//            id_*, exm_*, wb_*; observes ex_* and load_use_stall)
//   slave  : the id_ex_stage block itself
interface id_ex_stage_if #(
  parameter int DATA_W = 64,
  parameter int RA_W   = 5
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_rs1_data;
  logic [DATA_W-1:0] id_rs2_data;
  logic [DATA_W-1:0] id_imm;
  logic [RA_W-1:0]   id_rs1;
  logic [RA_W-1:0]   id_rs2;
  logic [RA_W-1:0]   id_rd;
  logic [1:0]        id_aluop;
  logic [2:0]        id_funct3;
  logic              id_funct7_b5;
  logic              id_alusrc;
  logic              id_branch;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_memtoreg;
  logic              id_regwrite;
  logic              exm_regwrite;
  logic [RA_W-1:0]   exm_rd;
  logic [DATA_W-1:0] exm_result;
  logic              wb_regwrite;
  logic [RA_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_result;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_a;
  logic [DATA_W-1:0] ex_alu_b;
  logic [3:0]        ex_alu_ctrl;
  logic [2:0]        ex_funct3;
  logic [DATA_W-1:0] ex_store_data;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_imm;
  logic [RA_W-1:0]   ex_rd;
  logic              ex_branch;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_memtoreg;
  logic              ex_regwrite;
  logic [1:0]        ex_fwd_a;
  logic [1:0]        ex_fwd_b;
  logic              load_use_stall;

  modport master (
    output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_aluop, id_funct3, id_funct7_b5,
           id_alusrc, id_branch, id_memread, id_memwrite, id_memtoreg,
           id_regwrite, exm_regwrite, exm_rd, exm_result,
           wb_regwrite, wb_rd, wb_result,
    input  ex_valid, ex_alu_a, ex_alu_b, ex_alu_ctrl, ex_funct3,
           ex_store_data, ex_pc, ex_imm, ex_rd, ex_branch, ex_memread,
           ex_memwrite, ex_memtoreg, ex_regwrite, ex_fwd_a, ex_fwd_b,
           load_use_stall
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_aluop, id_funct3, id_funct7_b5,
           id_alusrc, id_branch, id_memread, id_memwrite, id_memtoreg,
           id_regwrite, exm_regwrite, exm_rd, exm_result,
           wb_regwrite, wb_rd, wb_result,
    output ex_valid, ex_alu_a, ex_alu_b, ex_alu_ctrl, ex_funct3,
           ex_store_data, ex_pc, ex_imm, ex_rd, ex_branch, ex_memread,
           ex_memwrite, ex_memtoreg, ex_regwrite, ex_fwd_a, ex_fwd_b,
           load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with EX-side operand preparation feeding the ALU.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; clears every registered field
//   bus   - id_ex_stage_if.slave: stall/flush, decoded id_* fields,
//           EX/MEM and MEM/WB forwarding sources, registered ex_* outputs,
//           forwarding selects and the load-use stall request
// Configuration macro: ID_EX_FORWARD_EN
//   defined   - operands forwarded from EX/MEM (priority) then MEM/WB
//   undefined - operands come straight from the registered register-file
//               data, forwarding selects stay 00, exm_*/wb_* are ignored
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int RA_W   = 5
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [RA_W-1:0]   rd;
    logic [3:0]        alu_ctrl;
    logic [2:0]        funct3;
    logic              alusrc;
    logic              branch;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              regwrite;
  } ex_fields_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // b5 only selects SUB for R-type; I-type addi ignores it.
  function automatic logic [3:0] alu_ctrl_dec(input logic [1:0] aluop,
                                              input logic [2:0] funct3,
                                              input logic       b5);
    logic [3:0] ctrl;
    ctrl = ALU_NOP;
    case (aluop)
      2'b00: ctrl = ALU_ADD;
      2'b01: ctrl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  ctrl = (aluop == 2'b10 && b5) ? ALU_SUB : ALU_ADD;
          3'b111:  ctrl = ALU_AND;
          3'b110:  ctrl = ALU_OR;
          3'b001:  ctrl = ALU_SLL;
          default: ctrl = ALU_NOP;
        endcase
      end
    endcase
    return ctrl;
  endfunction

  ex_fields_t        r_ex_p1;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;
  logic [DATA_W-1:0] w_rs1_val;
  logic [DATA_W-1:0] w_rs2_val;

  // ---- stage p1: ID/EX register (flush beats stall) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_p1 <= '0;
    end else if (bus.flush) begin
      r_ex_p1 <= '0;
    end else if (!bus.stall) begin
      r_ex_p1.vld      <= bus.id_valid;
      r_ex_p1.pc       <= bus.id_pc;
      r_ex_p1.rs1_data <= bus.id_rs1_data;
      r_ex_p1.rs2_data <= bus.id_rs2_data;
      r_ex_p1.imm      <= bus.id_imm;
      r_ex_p1.rs1      <= bus.id_rs1;
      r_ex_p1.rs2      <= bus.id_rs2;
      r_ex_p1.rd       <= bus.id_rd;
      r_ex_p1.alu_ctrl <= alu_ctrl_dec(bus.id_aluop, bus.id_funct3, bus.id_funct7_b5);
      r_ex_p1.funct3   <= bus.id_funct3;
      r_ex_p1.alusrc   <= bus.id_alusrc;
      r_ex_p1.memtoreg <= bus.id_memtoreg;
      // Side-effecting controls are qualified so an empty slot never writes.
      r_ex_p1.branch   <= bus.id_branch   & bus.id_valid;
      r_ex_p1.memread  <= bus.id_memread  & bus.id_valid;
      r_ex_p1.memwrite <= bus.id_memwrite & bus.id_valid;
      r_ex_p1.regwrite <= bus.id_regwrite & bus.id_valid;
    end
  end

  // ---- EX side: operand forwarding from registered rs1/rs2 ----
`ifdef ID_EX_FORWARD_EN
  always_comb begin
    w_fwd_a = 2'b00;
    if (bus.exm_regwrite && bus.exm_rd != '0 && bus.exm_rd == r_ex_p1.rs1)
      w_fwd_a = 2'b10;
    else if (bus.wb_regwrite && bus.wb_rd != '0 && bus.wb_rd == r_ex_p1.rs1)
      w_fwd_a = 2'b01;
  end

  always_comb begin
    w_fwd_b = 2'b00;
    if (bus.exm_regwrite && bus.exm_rd != '0 && bus.exm_rd == r_ex_p1.rs2)
      w_fwd_b = 2'b10;
    else if (bus.wb_regwrite && bus.wb_rd != '0 && bus.wb_rd == r_ex_p1.rs2)
      w_fwd_b = 2'b01;
  end

  always_comb begin
    case (w_fwd_a)
      2'b10:   w_rs1_val = bus.exm_result;
      2'b01:   w_rs1_val = bus.wb_result;
      default: w_rs1_val = r_ex_p1.rs1_data;
    endcase
  end

  always_comb begin
    case (w_fwd_b)
      2'b10:   w_rs2_val = bus.exm_result;
      2'b01:   w_rs2_val = bus.wb_result;
      default: w_rs2_val = r_ex_p1.rs2_data;
    endcase
  end
`else
  logic w_unused_fwd;
  assign w_fwd_a   = 2'b00;
  assign w_fwd_b   = 2'b00;
  assign w_rs1_val = r_ex_p1.rs1_data;
  assign w_rs2_val = r_ex_p1.rs2_data;
  // Forwarding sources and registered source addresses have no consumer here.
  assign w_unused_fwd = ^{bus.exm_regwrite, bus.exm_rd, bus.exm_result,
                          bus.wb_regwrite, bus.wb_rd, bus.wb_result,
                          r_ex_p1.rs1, r_ex_p1.rs2};
`endif

  assign bus.ex_valid      = r_ex_p1.vld;
  assign bus.ex_alu_a      = w_rs1_val;
  assign bus.ex_alu_b      = r_ex_p1.alusrc ? r_ex_p1.imm : w_rs2_val;
  assign bus.ex_alu_ctrl   = r_ex_p1.alu_ctrl;
  assign bus.ex_funct3     = r_ex_p1.funct3;
  assign bus.ex_store_data = w_rs2_val;
  assign bus.ex_pc         = r_ex_p1.pc;
  assign bus.ex_imm        = r_ex_p1.imm;
  assign bus.ex_rd         = r_ex_p1.rd;
  assign bus.ex_branch     = r_ex_p1.branch;
  assign bus.ex_memread    = r_ex_p1.memread;
  assign bus.ex_memwrite   = r_ex_p1.memwrite;
  assign bus.ex_memtoreg   = r_ex_p1.memtoreg;
  assign bus.ex_regwrite   = r_ex_p1.regwrite;
  assign bus.ex_fwd_a      = w_fwd_a;
  assign bus.ex_fwd_b      = w_fwd_b;

  // A load in EX whose destination is read by the instruction in decode.
  assign bus.load_use_stall = r_ex_p1.vld & r_ex_p1.memread & (r_ex_p1.rd != '0) &
                              bus.id_valid &
                              ((r_ex_p1.rd == bus.id_rs1) | (r_ex_p1.rd == bus.id_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int DW = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DW), .RA_W(AW)) bus ();

  id_ex_stage #(.DATA_W(DW), .RA_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference view of what the EX stage should currently hold.
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc, rs1d, rs2d, imm;
    logic [AW-1:0] rs1, rs2, rd;
    logic [3:0]    ctrl;
    logic [2:0]    f3;
    logic          alusrc, branch, memread, memwrite, memtoreg, regwrite;
  } ex_t;

  ex_t m;
  ex_t held;
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Operation named by the instruction class, then its 4-bit code.
  function automatic logic [3:0] exp_ctrl(input logic [1:0] aluop, input logic [2:0] f3,
                                          input logic b5);
    if (aluop == 2'd0) return 4'b0010;               // load/store address add
    if (aluop == 2'd1) return 4'b0110;               // branch compare subtract
    if (f3 == 3'b000) return (aluop == 2'd2 && b5) ? 4'b0110 : 4'b0010;
    if (f3 == 3'b111) return 4'b0000;
    if (f3 == 3'b110) return 4'b0001;
    if (f3 == 3'b001) return 4'b1000;
    return 4'b1111;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
`ifdef ID_EX_FORWARD_EN
    if (bus.exm_regwrite && bus.exm_rd != 0 && bus.exm_rd == rs) return 2'b10;
    if (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == rs) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic logic [DW-1:0] fwd_value(input logic [1:0] sel, input logic [DW-1:0] regv);
    if (sel == 2'b10) return bus.exm_result;
    if (sel == 2'b01) return bus.wb_result;
    return regv;
  endfunction

  task automatic check_all();
    logic [1:0]    fa, fb;
    logic [DW-1:0] va, vb;
    logic          lu;
    fa = exp_fwd(m.rs1);
    fb = exp_fwd(m.rs2);
    va = fwd_value(fa, m.rs1d);
    vb = fwd_value(fb, m.rs2d);
    lu = m.valid && m.memread && m.rd != 0 && bus.id_valid &&
         (m.rd == bus.id_rs1 || m.rd == bus.id_rs2);
    chk("ex_valid", bus.ex_valid, m.valid);
    chk("ex_alu_a", bus.ex_alu_a, va);
    chk("ex_alu_b", bus.ex_alu_b, m.alusrc ? m.imm : vb);
    chk("ex_alu_ctrl", bus.ex_alu_ctrl, m.ctrl);
    chk("ex_funct3", bus.ex_funct3, m.f3);
    chk("ex_store_data", bus.ex_store_data, vb);
    chk("ex_pc", bus.ex_pc, m.pc);
    chk("ex_imm", bus.ex_imm, m.imm);
    chk("ex_rd", bus.ex_rd, m.rd);
    chk("ex_branch", bus.ex_branch, m.branch);
    chk("ex_memread", bus.ex_memread, m.memread);
    chk("ex_memwrite", bus.ex_memwrite, m.memwrite);
    chk("ex_memtoreg", bus.ex_memtoreg, m.memtoreg);
    chk("ex_regwrite", bus.ex_regwrite, m.regwrite);
    chk("ex_fwd_a", bus.ex_fwd_a, fa);
    chk("ex_fwd_b", bus.ex_fwd_b, fb);
    chk("load_use_stall", bus.load_use_stall, lu);
  endtask

  // Advance one clock and apply the register-update rules to the model.
  task automatic tick();
    @(posedge clk);
    if (reset || bus.flush) begin
      m = '0;
    end else if (!bus.stall) begin
      m.valid    = bus.id_valid;
      m.pc       = bus.id_pc;
      m.rs1d     = bus.id_rs1_data;
      m.rs2d     = bus.id_rs2_data;
      m.imm      = bus.id_imm;
      m.rs1      = bus.id_rs1;
      m.rs2      = bus.id_rs2;
      m.rd       = bus.id_rd;
      m.ctrl     = exp_ctrl(bus.id_aluop, bus.id_funct3, bus.id_funct7_b5);
      m.f3       = bus.id_funct3;
      m.alusrc   = bus.id_alusrc;
      m.memtoreg = bus.id_memtoreg;
      m.branch   = bus.id_branch & bus.id_valid;
      m.memread  = bus.id_memread & bus.id_valid;
      m.memwrite = bus.id_memwrite & bus.id_valid;
      m.regwrite = bus.id_regwrite & bus.id_valid;
    end
    #1;
  endtask

  task automatic drive_idle();
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_pc = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_aluop = '0; bus.id_funct3 = '0; bus.id_funct7_b5 = 0;
    bus.id_alusrc = 0; bus.id_branch = 0; bus.id_memread = 0; bus.id_memwrite = 0;
    bus.id_memtoreg = 0; bus.id_regwrite = 0;
    bus.exm_regwrite = 0; bus.exm_rd = '0; bus.exm_result = '0;
    bus.wb_regwrite = 0; bus.wb_rd = '0; bus.wb_result = '0;
  endtask

  // Small register range so hazards and forwarding matches occur often.
  task automatic rand_id();
    bus.id_valid = ($urandom_range(0, 3) != 0);
    bus.id_pc = {$urandom, $urandom}; bus.id_imm = {$urandom, $urandom};
    bus.id_rs1_data = {$urandom, $urandom}; bus.id_rs2_data = {$urandom, $urandom};
    bus.id_rs1 = AW'($urandom_range(0, 7)); bus.id_rs2 = AW'($urandom_range(0, 7));
    bus.id_rd = AW'($urandom_range(0, 7));
    bus.id_aluop = 2'($urandom_range(0, 3)); bus.id_funct3 = 3'($urandom_range(0, 7));
    bus.id_funct7_b5 = 1'($urandom); bus.id_alusrc = 1'($urandom);
    bus.id_branch = 1'($urandom); bus.id_memread = 1'($urandom);
    bus.id_memwrite = 1'($urandom); bus.id_memtoreg = 1'($urandom);
    bus.id_regwrite = 1'($urandom);
    bus.exm_regwrite = 1'($urandom); bus.exm_rd = AW'($urandom_range(0, 7));
    bus.exm_result = {$urandom, $urandom};
    bus.wb_regwrite = 1'($urandom); bus.wb_rd = AW'($urandom_range(0, 7));
    bus.wb_result = {$urandom, $urandom};
  endtask

  initial begin
    // Power-on reset
    reset = 1; drive_idle(); m = '0;
    #2 check_all();
    chk("reset_alu_ctrl", bus.ex_alu_ctrl, 4'b0000);
    tick();
    reset = 0;

    // Random captures
    repeat (6) begin
      rand_id(); tick(); check_all();
    end

    // Asynchronous reset mid-cycle
    rand_id(); bus.id_valid = 1; bus.id_regwrite = 1; tick();
    #2 reset = 1;
    #1 m = '0;
    check_all();
    chk("async_reset_valid", bus.ex_valid, 1'b0);
    chk("async_reset_pc", bus.ex_pc, 64'd0);
    tick(); check_all();
    reset = 0;
    rand_id(); bus.id_valid = 1; tick(); check_all();
    chk("post_reset_capture_valid", bus.ex_valid, 1'b1);

    // R-type sub
    drive_idle();
    bus.id_valid = 1; bus.id_aluop = 2'b10; bus.id_funct3 = 3'b000; bus.id_funct7_b5 = 1;
    bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.id_rd = 5'd3;
    bus.id_rs1_data = 64'd10; bus.id_rs2_data = 64'd3; bus.id_regwrite = 1;
    tick(); check_all();
    chk("sub_ctrl", bus.ex_alu_ctrl, 4'b0110);
    chk("sub_a", bus.ex_alu_a, 64'd10);
    chk("sub_b", bus.ex_alu_b, 64'd3);

    // I-type slli
    drive_idle();
    bus.id_valid = 1; bus.id_aluop = 2'b11; bus.id_funct3 = 3'b001; bus.id_imm = 64'd4;
    bus.id_alusrc = 1; bus.id_rs1 = 5'd4; bus.id_rs2 = 5'd4; bus.id_rd = 5'd6;
    bus.id_rs2_data = 64'h55; bus.id_regwrite = 1;
    tick(); check_all();
    chk("slli_ctrl", bus.ex_alu_ctrl, 4'b1000);
    chk("slli_b", bus.ex_alu_b, 64'd4);

    // Forwarding priority and x0
    drive_idle();
    bus.id_valid = 1; bus.id_aluop = 2'b10; bus.id_rs1 = 5'd5; bus.id_rs1_data = 64'h11;
    bus.id_rs2 = 5'd0; bus.id_rs2_data = 64'h22; bus.id_rd = 5'd9; bus.id_regwrite = 1;
    tick();
    bus.exm_regwrite = 1; bus.exm_rd = 5'd5; bus.exm_result = 64'hAA;
    bus.wb_regwrite = 1; bus.wb_rd = 5'd5; bus.wb_result = 64'hBB;
    #1 check_all();
`ifdef ID_EX_FORWARD_EN
    chk("fwd_exm_a", bus.ex_alu_a, 64'hAA);
    chk("fwd_exm_sel", bus.ex_fwd_a, 2'b10);
`else
    chk("nofwd_a", bus.ex_alu_a, 64'h11);
    chk("nofwd_sel", bus.ex_fwd_a, 2'b00);
`endif
    bus.exm_rd = 5'd0;
    #1 check_all();
`ifdef ID_EX_FORWARD_EN
    chk("fwd_wb_a", bus.ex_alu_a, 64'hBB);
    chk("fwd_wb_sel", bus.ex_fwd_a, 2'b01);
`endif
    bus.exm_rd = 5'd0; bus.wb_rd = 5'd0;
    #1 check_all();
    chk("x0_store_data", bus.ex_store_data, 64'h22);
    chk("x0_fwd_b", bus.ex_fwd_b, 2'b00);

    // Load-use hazard then flush
    drive_idle();
    bus.id_valid = 1; bus.id_memread = 1; bus.id_memtoreg = 1; bus.id_regwrite = 1;
    bus.id_alusrc = 1; bus.id_rs1 = 5'd2; bus.id_rd = 5'd7;
    tick();
    drive_idle();
    bus.id_valid = 1; bus.id_aluop = 2'b10; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd7;
    bus.id_rd = 5'd8; bus.id_regwrite = 1;
    #1 check_all();
    chk("load_use_hit", bus.load_use_stall, 1'b1);
    bus.flush = 1;
    tick(); check_all();
    chk("flush_valid", bus.ex_valid, 1'b0);
    chk("flush_regwrite", bus.ex_regwrite, 1'b0);

    // stall and flush together
    rand_id(); bus.flush = 0; bus.stall = 0; bus.id_valid = 1; bus.id_regwrite = 1;
    tick();
    bus.stall = 1; bus.flush = 1;
    tick(); check_all();
    chk("stall_flush_valid", bus.ex_valid, 1'b0);

    // stall alone holds contents for three cycles
    rand_id(); bus.stall = 0; bus.flush = 0; bus.id_valid = 1;
    tick(); held = m;
    repeat (3) begin
      rand_id(); bus.stall = 1; bus.flush = 0;
      tick(); check_all();
      chk("hold_pc", bus.ex_pc, held.pc);
      chk("hold_ctrl", bus.ex_alu_ctrl, held.ctrl);
      chk("hold_valid", bus.ex_valid, 1'b1);
    end

    // Random traffic
    repeat (400) begin
      rand_id();
      bus.stall = ($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      #1 check_all();
      tick(); check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand preparation. Sits directly upstream of the 64-bit ALU.
- Latches decoded instruction fields and generates the 4-bit ALU control code from ALUOp, funct3 and funct7[5].
- Resolves operand forwarding from EX/MEM and MEM/WB, then drives the ALU a/b operands.
- Detects load-use hazards for the decode stage.

Parameters:
- DATA_W, 64, operand/immediate/PC width
- RA_W, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  hold current ID/EX contents
- flush  in  1  insert bubble
- id_valid  in  1  decode slot holds an instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  DATA_W  decoded data
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses
- id_aluop  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- id_funct3  in  3  instruction funct3
- id_funct7_b5  in  1  instruction bit 30
- id_alusrc, id_branch, id_memread, id_memwrite, id_memtoreg, id_regwrite  in  1 each  control bits
- exm_regwrite  in  1  EX/MEM write enable
- exm_rd  in  RA_W  EX/MEM destination
- exm_result  in  DATA_W  EX/MEM result
- wb_regwrite  in  1  MEM/WB write enable
- wb_rd  in  RA_W  MEM/WB destination
- wb_result  in  DATA_W  MEM/WB result
- ex_valid  out  1  registered valid
- ex_alu_a, ex_alu_b  out  DATA_W  ALU operands
- ex_alu_ctrl  out  4  ALU control code
- ex_funct3  out  3  to ALU ZERO/branch-condition select
- ex_store_data  out  DATA_W  forwarded rs2 value
- ex_pc, ex_imm  out  DATA_W  to branch-target adder
- ex_rd  out  RA_W  registered destination
- ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite  out  1 each  registered controls
- ex_fwd_a, ex_fwd_b  out  2  00 register file, 10 EX/MEM, 01 MEM/WB
- load_use_stall  out  1  request to stall PC/IF/ID

Behaviour:
- Reset: all registered fields go to 0 immediately, so every ex_* output is 0 and ex_alu_ctrl = 4'b0000. With all controls 0, ex_alu_a = ex_alu_b = 0 and load_use_stall = 0.
- Register update, evaluated at each rising clk edge in priority order:
  - flush = 1: valid and all control bits become 0; data fields are don't-care, cleared to 0.
  - Else stall = 1: hold all contents.
  - Else: capture all id_* inputs; valid becomes id_valid.
- flush wins over stall when both are asserted in the same cycle.
- The controls regwrite, memread, memwrite and branch are captured as (id_* & id_valid), so a bubble never writes.
- ALU control is decoded at capture and registered, giving one-cycle latency:
  - aluop 00 → ADD 0010.
  - aluop 01 → SUB 0110.
  - aluop 10:
    - funct3 000 → ADD if b5 = 0, SUB if b5 = 1.
    - 111 → AND 0000.
    - 110 → OR 0001.
    - 001 → SLL 1000.
    - Any other funct3 → 1111 (ALU returns 0).
  - aluop 11: funct3 000 → ADD (b5 ignored); 001 → 1000; 111 → 0000; 110 → 0001; otherwise 1111.
- Forwarding is combinational from registered rs1/rs2:
  - EX/MEM match: exm_regwrite & exm_rd != 0 & exm_rd == rs.
  - MEM/WB match: the same test using the wb_* signals.
  - EX/MEM has priority over MEM/WB. Register x0 is never forwarded.
- Operand and store-data outputs:
  - ex_alu_a = forwarded rs1.
  - ex_alu_b = ex_imm when alusrc = 1, else forwarded rs2.
  - ex_store_data = forwarded rs2 regardless of alusrc.
- load_use_stall = ex_valid & ex_memread & ex_rd != 0 & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2). It is combinational.
  - The hazard unit externally asserts flush in the same cycle.
  - Reset mid-operation discards the in-flight instruction.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding as described above.
- Undefined:
  - ex_alu_a and ex_store_data come straight from the registered rs1/rs2 data.
  - ex_fwd_a = ex_fwd_b = 00.
  - The exm_* and wb_* inputs are ignored.
  - The software/compiler guarantees spacing between dependent instructions.

Test Plan:
- Reset asserted mid-cycle with stall = 0 → all outputs 0 immediately, without waiting for clk; after release, the first capture proceeds normally.
- R-type sub: aluop 10, funct3 000, b5 = 1, rs1_data = 10, rs2_data = 3 → next cycle ex_alu_ctrl = 0110, a = 10, b = 3.
- I-type slli: aluop 11, funct3 001, imm = 4, alusrc = 1 → ex_alu_ctrl = 1000, b = 4.
- Forwarding: registered rs1 = 5; exm_rd = 5 with exm_result = 0xAA, and wb_rd = 5 with wb_result = 0xBB, both regwrite = 1 → a = 0xAA, fwd_a = 10. Repeat with exm_rd = 0 → a = 0xBB, fwd_a = 01.
- Load-use: ex holds ld x7 (memread = 1), id_rs2 = 7, id_valid = 1 → load_use_stall = 1. Assert flush on the next edge → ex_valid = 0, ex_regwrite = 0.
- stall = 1 and flush = 1 together → bubble inserted. stall alone for 3 cycles → outputs unchanged.
